pc_fetch_unit: RTL and testbench
================================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 The unit SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- le  in  1  load enable; 0 = stall.
- flush  in  1  squash the IF/ID entry.
- next_npc  in  32  next nPC, selected by the branch-logic mux (target address, rs, or npc_plus4).
- instr_in  in  32  instruction-memory read data at address pc.
- pc  out  32  fetch address to instruction memory.
- npc  out  32  current nPC.
- npc_plus4  out  32  npc + 4, fed back to the branch-logic mux as its not-taken input.
- ifid_instr  out  32  IF/ID instruction.
- ifid_pc  out  32  IF/ID PC of that instruction.
- ifid_valid  out  1  IF/ID entry holds a real instruction.
- state  out  2  FSM state, for debug.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.

Function
REQ-003 The unit SHALL implement the delayed-branch PC/nPC pair: on each advancing edge, pc <= npc and npc <= next_npc.
- A taken branch therefore redirects one instruction after the branch, which gives one delay slot.
REQ-004 npc_plus4 SHALL equal npc + 32'd4, computed combinationally with 32-bit wrap-around (32'hFFFF_FFFC + 4 = 0).
REQ-005 The FSM SHALL have three states: RESET(0), START(1) and RUN(2); encoding 3 is illegal and SHALL return to RESET.
REQ-006 RESET SHALL be held while rst_n=0 and SHALL go to START on the first clock edge after release.
REQ-007 START SHALL load pc <= RESET_PC and npc <= RESET_PC+4, keep ifid_valid=0, and go to RUN unconditionally, ignoring le.
REQ-008 In RUN with le=1, the unit SHALL advance PC/nPC per REQ-003 and load ifid_instr <= instr_in, ifid_pc <= pc, and ifid_valid <= 1.
REQ-009 In RUN with le=0, pc, npc, ifid_instr, ifid_pc and ifid_valid SHALL all hold.
REQ-010 flush=1 in RUN SHALL clear ifid_valid and ifid_instr to 0 on that edge, overriding both le=0 and le=1 for the IF/ID register.
- With le=1, PC/nPC still advance.
- With le=0, PC/nPC hold.
REQ-011 Fetch-path latency SHALL be one cycle: the instr_in sampled at pc appears on ifid_instr on the next edge.
REQ-012 next_npc SHALL be sampled only on advancing edges.
- Its value during stalls, START and RESET SHALL have no effect.
REQ-013 Asserting rst_n=0 at any time, including mid-stall or mid-flush, SHALL immediately force the reset values of REQ-014.
- The unit SHALL then re-enter the RESET→START→RUN sequence.

Reset
REQ-014 While rst_n=0, outputs SHALL be asynchronously forced to:
- state = RESET
- pc = RESET_PC
- npc = RESET_PC + 4
- ifid_instr = 0
- ifid_pc = 0
- ifid_valid = 0
REQ-015 No output SHALL depend on le, flush or next_npc while rst_n=0.

Structure
REQ-016 The FSM state encoding constants and the instruction width (32) SHALL live in the shared CPU package.
- The same package SHALL hold the NOP encoding (32'h0000_0000).
REQ-017 The IF/ID pipeline register SHALL be a sub-module named ifid_register with inputs le, flush and valid_in; PC/nPC and the FSM stay in pc_fetch_unit.
REQ-018 The design SHALL use a single clock domain, with no latches and no combinational path from next_npc to pc.

Verification
REQ-019 Reset release: with RESET_PC=0, release rst_n, then run 3 edges with le=1 and next_npc=npc_plus4.
- Required: pc sequence 0, 4, 8.
- Required: ifid_valid=0 until the first RUN edge.
REQ-020 Delayed branch: the branch is at pc=8; during its fetch cycle next_npc=32'h40.
- Required: pc sequence 8, 12 (the delay slot), 0x40, 0x44.
REQ-021 Stall: in RUN at pc=0x10, hold le=0 for 3 cycles.
- Required: pc=0x10, npc=0x14 and ifid_* all unchanged.
- Required: the unit resumes at pc=0x14 after le returns to 1.
REQ-022 Flush with stall: ifid_valid=1 and ifid_instr=32'h2108_0001; apply flush=1 with le=0.
- Required: ifid_valid=0 and ifid_instr=0.
- Required: pc unchanged.
REQ-023 Wrap-around: force npc to 32'hFFFF_FFFC.
- Required: npc_plus4=0.
- Required: after 2 edges with not-taken next_npc, pc=0.
REQ-024 Mid-operation reset: assert rst_n=0 between clock edges during a stall.
- Required: pc=RESET_PC and state=RESET immediately, without waiting for a clock edge.
- Required: the full START→RUN sequence repeats after release.

Source files
------------

// File: rtl/pc_fetch_unit_pkg.sv
// rtl/pc_fetch_unit_pkg.sv - shared CPU constants for the fetch stage
// Holds the instruction width, the NOP encoding and the fetch FSM state
// encoding used by pc_fetch_unit and ifid_register.
package pc_fetch_unit_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_ifid_register.sv
// rtl/pc_fetch_unit_ifid_register.sv - IF/ID pipeline register with stall and flush
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   le                    load enable (0 = hold)
//   flush                 clear valid and instruction, wins over le
//   valid_in              valid bit loaded alongside the instruction
//   instr_in, pc_in       fetched instruction and its address
//   instr_out, pc_out     registered instruction and address
//   valid_out             entry holds a real instruction
module ifid_register
  import pc_fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               le,
  input  logic               flush,
  input  logic               valid_in,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [INSTR_W-1:0] pc_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [INSTR_W-1:0] pc_out,
  output logic               valid_out
);

  logic [INSTR_W-1:0] r_instr;
  logic [INSTR_W-1:0] r_pc;
  logic               r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_instr <= NOP_INSTR;
      r_pc    <= '0;
      r_valid <= 1'b0;
    end else if (flush) begin
      // The PC field is left alone: with valid cleared it is don't-care.
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (le) begin
      r_instr <= instr_in;
      r_pc    <= pc_in;
      r_valid <= valid_in;
    end
  end

  assign instr_out = r_instr;
  assign pc_out    = r_pc;
  assign valid_out = r_valid;

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - delayed-branch PC/nPC fetch unit with IF/ID register
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   le             load enable (0 = stall)
//   flush          squash the IF/ID entry
//   next_npc       next nPC chosen by the branch-logic mux
//   instr_in       instruction memory data at pc
//   pc, npc        fetch address and current nPC
//   npc_plus4      npc + 4, the not-taken input of the branch mux
//   ifid_instr     IF/ID instruction
//   ifid_pc        IF/ID address of that instruction
//   ifid_valid     IF/ID entry holds a real instruction
//   state          FSM state for debug
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               le,
  input  logic               flush,
  input  logic [INSTR_W-1:0] next_npc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic [INSTR_W-1:0] pc,
  output logic [INSTR_W-1:0] npc,
  output logic [INSTR_W-1:0] npc_plus4,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [INSTR_W-1:0] ifid_pc,
  output logic               ifid_valid,
  output logic [1:0]         state
);

  localparam logic [INSTR_W-1:0] RESET_NPC = RESET_PC + 32'd4;

  fetch_state_e       r_state;
  fetch_state_e       w_next_state;
  logic [INSTR_W-1:0] r_pc;
  logic [INSTR_W-1:0] r_npc;
  logic               w_advance;
  logic               w_ifid_le;
  logic               w_ifid_flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RESET;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = ST_RESET;
    w_advance    = 1'b0;
    w_ifid_le    = 1'b0;
    w_ifid_flush = 1'b0;
    case (r_state)
      ST_RESET: begin
        w_next_state = ST_START;
        w_ifid_flush = 1'b1;
      end
      ST_START: begin
        w_next_state = ST_RUN;
        w_ifid_flush = 1'b1;
      end
      ST_RUN: begin
        w_next_state = ST_RUN;
        w_advance    = le;
        w_ifid_le    = le;
        w_ifid_flush = flush;
      end
      default: begin
        // Illegal encoding: drop back to RESET and keep IF/ID empty.
        w_next_state = ST_RESET;
        w_ifid_flush = 1'b1;
      end
    endcase
  end

  // next_npc is only consumed on advancing edges, so it never reaches pc
  // combinationally and is ignored in RESET/START/stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc  <= RESET_PC;
      r_npc <= RESET_NPC;
    end else if (r_state == ST_START) begin
      r_pc  <= RESET_PC;
      r_npc <= RESET_NPC;
    end else if (w_advance) begin
      r_pc  <= r_npc;
      r_npc <= next_npc;
    end
  end

  ifid_register u_ifid (
    .clk       (clk),
    .rst_n     (rst_n),
    .le        (w_ifid_le),
    .flush     (w_ifid_flush),
    .valid_in  (1'b1),
    .instr_in  (instr_in),
    .pc_in     (r_pc),
    .instr_out (ifid_instr),
    .pc_out    (ifid_pc),
    .valid_out (ifid_valid)
  );

  assign pc        = r_pc;
  assign npc       = r_npc;
  assign npc_plus4 = r_npc + 32'd4;
  assign state     = r_state;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - directed scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        le;
  logic        flush;
  logic [31:0] next_npc;
  logic [31:0] instr_in;
  logic [31:0] pc;
  logic [31:0] npc;
  logic [31:0] npc_plus4;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic        ifid_valid;
  logic [1:0]  state;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .le         (le),
    .flush      (flush),
    .next_npc   (next_npc),
    .instr_in   (instr_in),
    .pc         (pc),
    .npc        (npc),
    .npc_plus4  (npc_plus4),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc),
    .ifid_valid (ifid_valid),
    .state      (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model
  int          m_state;
  logic [31:0] m_pc, m_npc;
  logic        e_valid;
  logic [31:0] e_instr, e_pc;
  logic [63:0] sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pc    = 32'h0;
    m_npc   = 32'h4;
    e_valid = 1'b0;
    e_instr = 32'h0;
    e_pc    = 32'h0;
    sb.delete();
  endtask

  task automatic check_all(input bit popped_expected);
    logic [63:0] ent;
    chk("state", {30'b0, state}, m_state[31:0]);
    chk("pc", pc, m_pc);
    chk("npc", npc, m_npc);
    chk("npc_plus4", npc_plus4, m_npc + 32'd4);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, e_valid});
    if (popped_expected) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        ent = sb.pop_front();
        chk("ifid_instr_sb", ifid_instr, ent[63:32]);
        chk("ifid_pc_sb", ifid_pc, ent[31:0]);
      end
    end else begin
      chk("ifid_instr", ifid_instr, e_instr);
      chk("ifid_pc", ifid_pc, e_pc);
    end
  endtask

  task automatic step(input logic le_i, input logic fl_i, input logic [31:0] nn,
                      input logic [31:0] ins);
    bit pushed;
    le       = le_i;
    flush    = fl_i;
    next_npc = nn;
    instr_in = ins;
    pushed   = 1'b0;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_state)
        0: m_state = 1;
        1: begin
          m_pc    = 32'h0;
          m_npc   = 32'h4;
          m_state = 2;
        end
        default: begin
          if (fl_i) begin
            e_valid = 1'b0;
            e_instr = 32'h0;
          end else if (le_i) begin
            sb.push_back({ins, m_pc});
            pushed  = 1'b1;
            e_valid = 1'b1;
            e_instr = ins;
            e_pc    = m_pc;
          end
          if (le_i) begin
            m_pc  = m_npc;
            m_npc = nn;
          end
        end
      endcase
    end
    #1;
    check_all(pushed);
  endtask

  // Not-taken advance with a random instruction word
  task automatic seq_step();
    step(1'b1, 1'b0, m_npc + 32'd4, $urandom);
  endtask

  initial begin
    model_reset();
    rst_n    = 1'b0;
    le       = 1'b1;
    flush    = 1'b0;
    next_npc = 32'h0;
    instr_in = 32'h0;

    // Reset state, and insensitivity to le/flush/next_npc while held
    repeat (2) @(posedge clk);
    #1;
    check_all(1'b0);
    step(1'b0, 1'b1, 32'hDEAD_BEEF, 32'h1234_5678);
    step(1'b1, 1'b0, 32'h0BAD_F00D, 32'h8765_4321);

    // Reset release: RESET -> START -> RUN, pc 0, 4, 8
    rst_n = 1'b1;
    step(1'b1, 1'b0, 32'hCAFE_0000, $urandom);
    chk("start_state", {30'b0, state}, 32'd1);
    step(1'b1, 1'b0, 32'hCAFE_0004, $urandom);
    chk("run_pc0", pc, 32'h0);
    seq_step();
    chk("run_pc4", pc, 32'h4);
    seq_step();
    chk("run_pc8", pc, 32'h8);

    // Delayed branch at pc=8 to 0x40
    step(1'b1, 1'b0, 32'h40, $urandom);
    chk("delay_slot_pc", pc, 32'hC);
    seq_step();
    chk("branch_target_pc", pc, 32'h40);
    seq_step();
    chk("branch_next_pc", pc, 32'h44);

    // Steer to pc=0x10, then stall for 3 cycles
    step(1'b1, 1'b0, 32'h10, $urandom);
    step(1'b1, 1'b0, 32'h14, $urandom);
    chk("stall_entry_pc", pc, 32'h10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, $urandom, $urandom);
    chk("stall_pc", pc, 32'h10);
    chk("stall_npc", npc, 32'h14);
    seq_step();
    chk("resume_pc", pc, 32'h14);

    // Flush with stall, then flush while advancing
    step(1'b1, 1'b0, m_npc + 32'd4, 32'h2108_0001);
    chk("pre_flush_instr", ifid_instr, 32'h2108_0001);
    step(1'b0, 1'b1, $urandom, $urandom);
    step(1'b1, 1'b1, m_npc + 32'd4, $urandom);
    seq_step();

    // Wrap-around: branch nPC to 0xFFFF_FFFC
    step(1'b1, 1'b0, 32'hFFFF_FFFC, $urandom);
    chk("wrap_npc_plus4", npc_plus4, 32'h0);
    seq_step();
    seq_step();
    chk("wrap_pc", pc, 32'h0);

    // Mid-stall asynchronous reset, then the full start sequence again
    step(1'b0, 1'b0, $urandom, $urandom);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all(1'b0);
    step(1'b0, 1'b1, $urandom, $urandom);
    rst_n = 1'b1;
    step(1'b0, 1'b0, $urandom, $urandom);
    step(1'b0, 1'b0, $urandom, $urandom);
    seq_step();
    seq_step();
    chk("rerun_pc8", pc, 32'h8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
